// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: load FSM states
// and the byte/word geometry used by the packer and the controller.
package common;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } load_state_t;

endpackage

// File: rtl/imem_load_ctrl_byte_word_packer.sv
// Assembles a little-endian instruction word from a byte stream; the first
// byte of a word lands in bits 7:0.
module byte_word_packer
    import common::*;
#(
    parameter int DATA_WIDTH = BYTES_PER_WORD * BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_last_byte
);

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_word;

    // NOTE: sequential state is only ever updated with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (i_shift) begin
            r_word  <= {i_byte, r_word[DATA_WIDTH-1:BYTE_WIDTH]};
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word      = r_word;
    assign o_last_byte = i_shift && (r_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot loader for program_memory: collects bytes into words, writes them
// sequentially from address 0, and muxes the memory port back to the CPU when idle.
module imem_load_ctrl
    import common::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0]    fetch_data,
    output logic                     fetch_valid,
    output logic                     mem_write_en,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     load_error
);

    localparam logic [ADDRESS_WIDTH:0]   DEPTH   = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    load_state_t              r_state;
    logic [ADDRESS_WIDTH-1:0] r_word_ptr;
    logic [ADDRESS_WIDTH-1:0] r_last_ptr;
    logic                     r_load_error;

    logic                     w_start_ok;
    logic                     w_abort_ok;
    logic                     w_accept;
    logic                     w_word_done;
    logic [ADDRESS_WIDTH-1:0] w_last_ptr;
    logic [DATA_WIDTH-1:0]    w_word;

    assign w_start_ok = start && (r_state == IDLE);
    assign w_abort_ok = abort && ((r_state == COLLECT) || (r_state == WRITE));
    assign w_accept   = in_valid && (r_state == COLLECT);

    // Requests beyond memory depth stop at the top address instead of wrapping.
    assign w_last_ptr = (word_count >= DEPTH) ? '1
                                              : word_count[ADDRESS_WIDTH-1:0] - PTR_ONE;

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_ok || w_abort_ok),
        .i_shift     (w_accept),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_last_byte (w_word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_word_ptr   <= '0;
            r_last_ptr   <= '0;
            r_load_error <= 1'b0;
        end else begin
            // NOTE: every branch assigns a known next state, including default,
            // so a corrupted encoding recovers to IDLE rather than holding.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_load_error <= 1'b0;
                        r_word_ptr   <= '0;
                        r_last_ptr   <= w_last_ptr;
                        r_state      <= (word_count == '0) ? FINISH : COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        r_load_error <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_word_done) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        r_load_error <= 1'b1;
                        r_state      <= IDLE;
                    end else if (r_word_ptr == r_last_ptr) begin
                        r_state <= FINISH;
                    end else begin
                        r_word_ptr <= r_word_ptr + PTR_ONE;
                        r_state    <= COLLECT;
                    end
                end
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // All control outputs decode the registered state, so an async reset
    // drives them to their idle values immediately.
    assign busy           = (r_state != IDLE);
    assign cpu_hold       = busy;
    assign fetch_valid    = !cpu_hold;
    assign done           = (r_state == FINISH);
    assign in_ready       = (r_state == COLLECT);
    assign mem_write_en   = (r_state == WRITE) && !abort;
    assign mem_address    = (r_state == IDLE) ? fetch_addr : r_word_ptr;
    assign mem_write_data = w_word;
    assign fetch_data     = mem_read_data;
    assign load_error     = r_load_error;

endmodule
